regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Register-file access sequencer sitting directly upstream of the 32x32 register file. It accepts decoded instructions over a valid/ready handshake and drives the register file's two read addresses. It waits out the register file's one-cycle registered read and presents both operands downstream over a second valid/ready handshake. It also buffers writeback requests in a small queue and issues them to the register file's single write port, with writes taking priority over reads.

## Interface
Parameters:
- WBQ_DEPTH, 2, writeback queue entries; power of two, at least 2.

Ports:
- RSQ_clk  in  1  single clock, rising edge.
- RSQ_rst_n  in  1  reset, asynchronous, active-low.
- RSQ_instr_valid  in  1  instruction offered.
- RSQ_instr  in  32  MIPS instruction word; rs = [25:21], rt = [20:16].
- RSQ_instr_ready  out  1  instruction accepted when high together with valid.
- RSQ_wb_valid  in  1  writeback request offered.
- RSQ_wb_addr  in  5  writeback destination register.
- RSQ_wb_data  in  32  writeback data.
- RSQ_wb_ready  out  1  writeback request accepted when high together with valid.
- RSQ_op_valid  out  1  operands valid.
- RSQ_op_ready  in  1  downstream consumer takes the operands.
- RSQ_op_a  out  32  value of register rs.
- RSQ_op_b  out  32  value of register rt.
- RSQ_op_instr  out  32  instruction the operands belong to.
- RSQ_rf_addr1  out  5  register file read address 1.
- RSQ_rf_addr2  out  5  register file read address 2.
- RSQ_rf_addr_wr  out  5  register file write address.
- RSQ_rf_write  out  1  register file write enable. The register file does not update its read outputs in a cycle where this is high.
- RSQ_rf_data_wr  out  32  register file write data.
- RSQ_rf_data1  in  32  register file read data 1, registered inside the register file.
- RSQ_rf_data2  in  32  register file read data 2, registered inside the register file.

## Operation
- FSM states: IDLE, CAPT, OUT.
- **IDLE**
  - If the queue is not empty, assert RSQ_rf_write with the head entry's address and data, and pop the entry at the clock edge. RSQ_instr_ready = 0.
  - Otherwise, RSQ_instr_ready = 1 and RSQ_rf_addr1/2 are driven combinationally from RSQ_instr rs/rt.
  - On an instruction handshake, register the instruction and go to CAPT.
- **CAPT**
  - RSQ_rf_write = 0; RSQ_rf_addr1/2 come from the registered instruction.
  - At the edge, load RSQ_op_a ← RSQ_rf_data1 and RSQ_op_b ← RSQ_rf_data2, then go to OUT.
- **OUT**
  - RSQ_op_valid = 1; RSQ_op_a, RSQ_op_b and RSQ_op_instr hold stable.
  - Queued writes may issue in this state exactly as in IDLE.
  - On RSQ_op_valid && RSQ_op_ready, go to IDLE.
- **Writeback queue**
  - FIFO of WBQ_DEPTH entries; RSQ_wb_ready = !full.
  - A request with RSQ_wb_addr == 0 is accepted but not enqueued; it is dropped.
  - Push and pop in the same cycle is legal and leaves the count unchanged. While full, ready stays 0 even if an entry is popping that cycle.
- **Idle outputs**
  - When not writing: RSQ_rf_write = 0, RSQ_rf_addr_wr = 0, RSQ_rf_data_wr = 0.
- **Ordering**
  - Operands reflect every writeback accepted before the acceptance cycle of that instruction.
  - A writeback accepted in the same cycle as the instruction is not reflected in that instruction's operands.
- **Starvation**
  - A continuous writeback stream can starve instruction acceptance indefinitely. This is intended.

## Timing
- **Reset**
  - While RSQ_rst_n is low: state = IDLE, queue empty, RSQ_op_valid = 0, RSQ_op_a/b/instr = 0.
  - Also while low: RSQ_instr_ready = 0, RSQ_wb_ready = 0, RSQ_rf_write = 0, and all RSQ_rf_* address/data outputs = 0.
  - Assertion mid-operation discards the in-flight instruction and all queued writebacks immediately, with no handshake completion.
- **Latency**
  - Instruction accepted at edge E. RSQ_op_valid rises after edge E+1.
  - Minimum per-instruction period is 3 cycles, with RSQ_op_ready held at 1 and the queue empty.
- **Writeback latency**
  - Request accepted at edge E with the queue empty. RSQ_rf_write is high in the cycle after E, provided the state is IDLE or OUT; during CAPT the write waits until the state is IDLE or OUT.
- **Outputs**
  - RSQ_op_* outputs are registered.
  - RSQ_instr_ready, RSQ_wb_ready and RSQ_rf_* outputs are combinational from state, queue and RSQ_instr only. No combinational path from RSQ_op_ready.

## Test plan
- Preload via writebacks r3 = 0x0000_0011 and r4 = 0x0000_0022. Then send instr 0x0064_2820 (rs = 3, rt = 4) with RSQ_op_ready = 1. Expect RSQ_op_valid 2 cycles after acceptance with op_a = 0x11, op_b = 0x22, op_instr = 0x0064_2820.
- Writeback r3 = 0xAAAA_AAAA accepted one cycle before an instr reading r3. Expect instr_ready = 0 until the write issues, then op_a = 0xAAAA_AAAA. Same writeback accepted in the same cycle as the instruction: expect the old value.
- Three back-to-back writebacks with WBQ_DEPTH = 2 while in CAPT. Expect RSQ_wb_ready = 0 on the third until a pop, and register-file writes in FIFO order.
- Writeback to r0 with data 0xFFFF_FFFF. Expect accepted with no RSQ_rf_write pulse; a later read of r0 gives op_a = 0.
- Hold RSQ_op_ready = 0 for 5 cycles in OUT while a writeback arrives. Expect operands stable, the write issued during OUT, and the next instruction accepted only after the op handshake.
- Assert RSQ_rst_n low during CAPT with 1 queued write. Expect all outputs at reset values immediately, no RSQ_rf_write after release, and normal operation after release.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: sequences operand reads and queued writebacks for a 32x32 register file.
//   RSQ_clk/RSQ_rst_n   : clock, asynchronous active-low reset
//   RSQ_instr_*         : decoded instruction in (valid/ready)
//   RSQ_wb_*            : writeback requests in (valid/ready), buffered in a WBQ_DEPTH FIFO
//   RSQ_op_*            : registered operands out (valid/ready)
//   RSQ_rf_*            : register file read/write port drive and registered read data
module regfile_sequencer #(
    parameter int WBQ_DEPTH = 2
) (
    input  logic        RSQ_clk,
    input  logic        RSQ_rst_n,
    input  logic        RSQ_instr_valid,
    input  logic [31:0] RSQ_instr,
    output logic        RSQ_instr_ready,
    input  logic        RSQ_wb_valid,
    input  logic [4:0]  RSQ_wb_addr,
    input  logic [31:0] RSQ_wb_data,
    output logic        RSQ_wb_ready,
    output logic        RSQ_op_valid,
    input  logic        RSQ_op_ready,
    output logic [31:0] RSQ_op_a,
    output logic [31:0] RSQ_op_b,
    output logic [31:0] RSQ_op_instr,
    output logic [4:0]  RSQ_rf_addr1,
    output logic [4:0]  RSQ_rf_addr2,
    output logic [4:0]  RSQ_rf_addr_wr,
    output logic        RSQ_rf_write,
    output logic [31:0] RSQ_rf_data_wr,
    input  logic [31:0] RSQ_rf_data1,
    input  logic [31:0] RSQ_rf_data2
);
    localparam int AW = $clog2(WBQ_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPT, OUT} state_t;

    state_t        state, state_nx;
    logic [31:0]   instr_q;
    logic [4:0]    q_addr [WBQ_DEPTH];
    logic [31:0]   q_data [WBQ_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, instr_take, op_take;

    assign full  = count == (AW+1)'(WBQ_DEPTH);
    assign empty = count == '0;

    always_comb begin
        state_nx        = state;
        // Outputs are forced to their reset values while reset is held, since
        // the queue/state decode alone would otherwise advertise readiness.
        RSQ_wb_ready    = RSQ_rst_n && !full;
        // Writes win the port whenever the register file is not mid-capture.
        pop             = RSQ_rst_n && !empty && state != CAPT;
        RSQ_instr_ready = RSQ_rst_n && empty && state == IDLE;
        push            = RSQ_wb_valid && RSQ_wb_ready && RSQ_wb_addr != 5'd0;
        instr_take      = RSQ_instr_valid && RSQ_instr_ready;
        op_take         = RSQ_op_valid && RSQ_op_ready;
        RSQ_rf_write    = pop;
        RSQ_rf_addr_wr  = pop ? q_addr[rd_ptr] : 5'd0;
        RSQ_rf_data_wr  = pop ? q_data[rd_ptr] : 32'd0;
        RSQ_rf_addr1    = !RSQ_rst_n ? 5'd0 : state == IDLE ? RSQ_instr[25:21] : instr_q[25:21];
        RSQ_rf_addr2    = !RSQ_rst_n ? 5'd0 : state == IDLE ? RSQ_instr[20:16] : instr_q[20:16];
        case (state)
            IDLE:    state_nx = instr_take ? CAPT : IDLE;
            CAPT:    state_nx = OUT;
            OUT:     state_nx = op_take ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge RSQ_clk or negedge RSQ_rst_n) begin
        if (!RSQ_rst_n) begin
            state        <= IDLE;
            instr_q      <= '0;
            RSQ_op_valid <= 1'b0;
            RSQ_op_a     <= '0;
            RSQ_op_b     <= '0;
            RSQ_op_instr <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            state <= state_nx;
            if (instr_take)
                instr_q <= RSQ_instr;
            // Read data for the captured instruction is valid during CAPT only.
            if (state == CAPT) begin
                RSQ_op_a     <= RSQ_rf_data1;
                RSQ_op_b     <= RSQ_rf_data2;
                RSQ_op_instr <= instr_q;
                RSQ_op_valid <= 1'b1;
            end else if (op_take) begin
                RSQ_op_valid <= 1'b0;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge RSQ_clk) begin
        if (push) begin
            q_addr[wr_ptr] <= RSQ_wb_addr;
            q_data[wr_ptr] <= RSQ_wb_data;
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed checks of regfile_sequencer against a behavioural register file.
module tb_regfile_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid, instr_ready, wb_valid, wb_ready;
    logic        op_valid, op_ready, rf_write;
    logic [31:0] instr, wb_data, op_a, op_b, op_instr, rf_data_wr;
    logic [4:0]  wb_addr, rf_addr1, rf_addr2, rf_addr_wr;
    logic [31:0] rf [32] = '{default: 32'd0};
    logic [31:0] rf_d1 = 32'd0, rf_d2 = 32'd0;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.WBQ_DEPTH(2)) dut (
        .RSQ_clk(clk), .RSQ_rst_n(rst_n),
        .RSQ_instr_valid(instr_valid), .RSQ_instr(instr), .RSQ_instr_ready(instr_ready),
        .RSQ_wb_valid(wb_valid), .RSQ_wb_addr(wb_addr), .RSQ_wb_data(wb_data), .RSQ_wb_ready(wb_ready),
        .RSQ_op_valid(op_valid), .RSQ_op_ready(op_ready),
        .RSQ_op_a(op_a), .RSQ_op_b(op_b), .RSQ_op_instr(op_instr),
        .RSQ_rf_addr1(rf_addr1), .RSQ_rf_addr2(rf_addr2), .RSQ_rf_addr_wr(rf_addr_wr),
        .RSQ_rf_write(rf_write), .RSQ_rf_data_wr(rf_data_wr),
        .RSQ_rf_data1(rf_d1), .RSQ_rf_data2(rf_d2)
    );

    // Register file: r0 reads zero, registered reads frozen during a write cycle.
    always @(posedge clk) begin
        if (rf_write && rf_addr_wr != 5'd0)
            rf[rf_addr_wr] <= rf_data_wr;
        if (!rf_write) begin
            rf_d1 <= rf[rf_addr1];
            rf_d2 <= rf[rf_addr2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_push(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        for (int i = 0; i < 20 && !wb_ready; i++)
            step();
        chk("wb_ready_wait", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_valid = 1'b0;
        wb_valid    = 1'b0;
        op_ready    = 1'b1;
        instr       = 32'h0064_2820;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        #2;
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_wb_ready", 32'(wb_ready), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_rf_addr1", 32'(rf_addr1), 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        // Preload r3/r4 and read them back.
        wb_push(5'd3, 32'h11);
        chk("wb1_write", 32'(rf_write), 32'd1);
        chk("wb1_addr", 32'(rf_addr_wr), 32'd3);
        chk("wb1_data", rf_data_wr, 32'h11);
        wb_push(5'd4, 32'h22);
        chk("wb2_addr", 32'(rf_addr_wr), 32'd4);
        chk("wb2_data", rf_data_wr, 32'h22);
        step();
        chk("wb_idle_write", 32'(rf_write), 32'd0);
        chk("wb_idle_addr", 32'(rf_addr_wr), 32'd0);
        instr_valid = 1'b1;
        chk("t1_instr_ready", 32'(instr_ready), 32'd1);
        chk("t1_rf_addr1", 32'(rf_addr1), 32'd3);
        chk("t1_rf_addr2", 32'(rf_addr2), 32'd4);
        step();
        instr_valid = 1'b0;
        chk("t1_capt_valid", 32'(op_valid), 32'd0);
        step();
        chk("t1_op_valid", 32'(op_valid), 32'd1);
        chk("t1_op_a", op_a, 32'h11);
        chk("t1_op_b", op_b, 32'h22);
        chk("t1_op_instr", op_instr, 32'h0064_2820);
        step();
        chk("t1_op_done", 32'(op_valid), 32'd0);
        // Writeback one cycle ahead of the instruction is reflected.
        wb_push(5'd3, 32'hAAAA_AAAA);
        instr_valid = 1'b1;
        chk("t2_blocked", 32'(instr_ready), 32'd0);
        chk("t2_write", 32'(rf_write), 32'd1);
        step();
        chk("t2_unblocked", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        step();
        chk("t2_op_a_new", op_a, 32'hAAAA_AAAA);
        step();
        // Writeback in the acceptance cycle is not reflected.
        instr_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_addr     = 5'd3;
        wb_data     = 32'h1234_5678;
        chk("t2s_instr_ready", 32'(instr_ready), 32'd1);
        chk("t2s_wb_ready", 32'(wb_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        wb_valid    = 1'b0;
        chk("t2s_capt_nowrite", 32'(rf_write), 32'd0);
        step();
        chk("t2s_op_a_old", op_a, 32'hAAAA_AAAA);
        chk("t2s_out_write", 32'(rf_write), 32'd1);
        chk("t2s_out_data", rf_data_wr, 32'h1234_5678);
        step();
        chk("t2s_drained", 32'(rf_write), 32'd0);
        // Queue fills during CAPT; FIFO order r5, r6, r7.
        instr       = 32'h00A6_0000;
        instr_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_addr     = 5'd5;
        wb_data     = 32'h5;
        step();
        instr_valid = 1'b0;
        wb_addr     = 5'd6;
        wb_data     = 32'h6;
        chk("t3_capt_ready", 32'(wb_ready), 32'd1);
        chk("t3_capt_nowrite", 32'(rf_write), 32'd0);
        step();
        wb_addr = 5'd7;
        wb_data = 32'h7;
        chk("t3_full_ready", 32'(wb_ready), 32'd0);
        chk("t3_op_a", op_a, 32'd0);
        chk("t3_first_addr", 32'(rf_addr_wr), 32'd5);
        chk("t3_first_data", rf_data_wr, 32'h5);
        step();
        chk("t3_ready_again", 32'(wb_ready), 32'd1);
        chk("t3_second_addr", 32'(rf_addr_wr), 32'd6);
        step();
        wb_valid = 1'b0;
        chk("t3_third_addr", 32'(rf_addr_wr), 32'd7);
        chk("t3_third_data", rf_data_wr, 32'h7);
        step();
        chk("t3_empty", 32'(rf_write), 32'd0);
        // Writeback to r0 is dropped.
        wb_push(5'd0, 32'hFFFF_FFFF);
        chk("t4_no_write", 32'(rf_write), 32'd0);
        chk("t4_wb_ready", 32'(wb_ready), 32'd1);
        instr       = 32'h0005_0000;
        instr_valid = 1'b1;
        chk("t4_instr_ready", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        step();
        chk("t4_op_a_r0", op_a, 32'd0);
        chk("t4_op_b_r5", op_b, 32'h5);
        step();
        // Back-pressure in OUT with a writeback issuing meanwhile.
        instr       = 32'h00C7_0000;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        chk("t5_op_a", op_a, 32'h6);
        chk("t5_op_b", op_b, 32'h7);
        op_ready = 1'b0;
        wb_valid = 1'b1;
        wb_addr  = 5'd8;
        wb_data  = 32'h88;
        step();
        wb_valid    = 1'b0;
        instr       = 32'h0100_0000;
        instr_valid = 1'b1;
        chk("t5_out_write", 32'(rf_write), 32'd1);
        chk("t5_out_addr", 32'(rf_addr_wr), 32'd8);
        chk("t5_blocked", 32'(instr_ready), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_valid", 32'(op_valid), 32'd1);
            chk("t5_hold_a", op_a, 32'h6);
            chk("t5_hold_b", op_b, 32'h7);
            chk("t5_hold_blocked", 32'(instr_ready), 32'd0);
            step();
        end
        op_ready = 1'b1;
        chk("t5_still_valid", 32'(op_valid), 32'd1);
        step();
        chk("t5_accept_ready", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        step();
        chk("t5_op_a_r8", op_a, 32'h88);
        chk("t5_op_instr", op_instr, 32'h0100_0000);
        step();
        // Reset during CAPT with a queued write.
        instr       = 32'h0120_0000;
        instr_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_addr     = 5'd9;
        wb_data     = 32'h99;
        step();
        instr_valid = 1'b0;
        wb_valid    = 1'b0;
        chk("t6_capt_addr1", 32'(rf_addr1), 32'd9);
        rst_n = 1'b0;
        #1;
        chk("t6_op_valid", 32'(op_valid), 32'd0);
        chk("t6_op_a", op_a, 32'd0);
        chk("t6_op_instr", op_instr, 32'd0);
        chk("t6_instr_ready", 32'(instr_ready), 32'd0);
        chk("t6_wb_ready", 32'(wb_ready), 32'd0);
        chk("t6_rf_write", 32'(rf_write), 32'd0);
        chk("t6_rf_addr1", 32'(rf_addr1), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_write", 32'(rf_write), 32'd0);
        chk("t6_post_wb_ready", 32'(wb_ready), 32'd1);
        chk("t6_post_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        chk("t6_op_a_r9", op_a, 32'd0);
        chk("t6_op_instr_new", op_instr, 32'h0120_0000);
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
